l_stf_streamer: RTL

//  Sequencer directly downstream of the 16-entry L-STF sample ROM. On a start pulse it drives the
//  ROM address, fetches packed I/Q words and streams NUM_REP periods (160 samples default) to the
//  TX sample path over a valid/ready handshake, windowing the first sample of the burst.

---
 rtl/l_stf_streamer.sv | 104 ++++++++++
 1 files changed

// File: rtl/l_stf_streamer.sv
// L-STF burst sequencer: walks the 16-entry STF ROM NUM_REP times and
// streams the samples over valid/ready, halving the very first sample.
module l_stf_streamer #(
    parameter int NUM_REP   = 10,
    parameter bit WINDOW_EN = 1'b1
) (
    input  logic        clk,
    input  logic        phy_tx_arest,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [3:0]  rom_addr,
    input  logic [31:0] rom_dout,
    output logic [31:0] result_iq,
    output logic        result_iq_valid,
    input  logic        result_iq_ready,
    output logic [7:0]  sample_idx
);

    localparam logic [7:0] LAST = 8'(16 * NUM_REP - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t      state_q;
    logic [7:0]  fcnt_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] iq_q;
    logic        valid_q;
    logic [7:0]  idx_q;

    logic        start_ok;
    logic        hs;
    logic        load;
    logic [31:0] iq_d;

    always_comb begin
        start_ok = start && (state_q == IDLE) && !done_q;
        hs       = valid_q && result_iq_ready;
        // Sample 0 is loaded on the accepting edge so it is valid one cycle after start.
        load     = start_ok ||
                   ((state_q == STREAM) && (!valid_q || result_iq_ready));
        iq_d     = rom_dout;
        if (WINDOW_EN && (fcnt_q == 8'd0)) begin
            iq_d = {rom_dout[31], rom_dout[31:17], rom_dout[15], rom_dout[15:1]};
        end
    end

    always_ff @(posedge clk or posedge phy_tx_arest) begin
        if (phy_tx_arest) begin
            state_q <= IDLE;
            fcnt_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            iq_q    <= 32'd0;
            valid_q <= 1'b0;
            idx_q   <= 8'd0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                iq_q    <= iq_d;
                idx_q   <= fcnt_q;
                valid_q <= 1'b1;
                fcnt_q  <= fcnt_q + 8'd1;
            end else if (hs) begin
                valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q <= STREAM;
                        busy_q  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (load && (fcnt_q == LAST)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        fcnt_q  <= 8'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign rom_addr        = fcnt_q[3:0];
    assign result_iq       = iq_q;
    assign result_iq_valid = valid_q;
    assign sample_idx      = idx_q;

endmodule
